// File: rtl/tjrpu_pkg.sv
// Shared constants for the tjrpu Wishbone register front end:
// register offsets, CTRL/STATUS bit positions and the STATUS packing helper.
package tjrpu_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h3000_0000;

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CMD    = 2'd2,
        REG_RESULT = 2'd3
    } reg_off_e;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int CTRL_FLUSH_BIT  = 2;

    localparam int ST_FULL_BIT  = 0;
    localparam int ST_EMPTY_BIT = 1;
    localparam int ST_HELD_BIT  = 2;
    localparam int ST_OVF_BIT   = 3;
    localparam int ST_CNT_LSB   = 4;

    function automatic logic [31:0] pack_status(
        input logic       full,
        input logic       empty,
        input logic       held,
        input logic       ovf,
        input logic [3:0] cnt
    );
        logic [31:0] st;
        st                           = 32'h0000_0000;
        st[ST_FULL_BIT]              = full;
        st[ST_EMPTY_BIT]             = empty;
        st[ST_HELD_BIT]              = held;
        st[ST_OVF_BIT]               = ovf;
        st[ST_CNT_LSB+3:ST_CNT_LSB]  = cnt;
        return st;
    endfunction

endpackage

// File: rtl/tjrpu_cmd_fifo.sv
// Synchronous command FIFO; flush has priority over push and pop on the same edge.
module tjrpu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [31:0]   push_data,
    input  logic          pop,
    input  logic          flush,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic [31:0]   head
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [31:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    // Full/empty qualification uses the count before this edge.
    always_comb begin
        push_ok_s = push & (count_r != CNT_FULL);
        pop_ok_s  = pop & (count_r != {CW{1'b0}});
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
        end else if (push_ok_s && !flush) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign full  = (count_r == CNT_FULL);
    assign empty = (count_r == {CW{1'b0}});
    assign count = count_r;
    assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/tjrpu_wb_regs.sv
// Wishbone slave register block for tjrpu: CTRL/STATUS/CMD/RESULT, command FIFO
// feeding the core, one-word result slot, core enable and level interrupt.
module tjrpu_wb_regs
    import tjrpu_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        cmd_valid_o,
    output logic [31:0] cmd_data_o,
    input  logic        cmd_ready_i,
    input  logic        res_valid_i,
    input  logic [31:0] res_data_i,
    output logic        res_ready_o,
    output logic        core_en_o,
    output logic        irq_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          ack_r;
    logic [31:0]   dat_r;
    logic          enable_r;
    logic          irq_en_r;
    logic          overflow_r;
    logic          res_held_r;
    logic [31:0]   res_r;
    logic          irq_r;

    reg_off_e      reg_s;
    logic          hit_s;
    logic          xfer_s;
    logic          wr_s;
    logic          rd_s;
    logic          ctrl_wr_s;
    logic          push_s;
    logic          pop_s;
    logic          flush_s;
    logic          ovf_set_s;
    logic          ovf_clr_s;
    logic          res_clear_s;
    logic          capture_s;
    logic [31:0]   rdata_s;
    logic [31:0]   count_ext_s;
    logic          full_s;
    logic          empty_s;
    logic [CW-1:0] count_s;
    logic [31:0]   head_s;
    logic          unused_s;

    // A transaction commits only on the cycle ack is low, so each access acts once.
    always_comb begin
        hit_s       = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
        xfer_s      = hit_s & ~ack_r;
        wr_s        = xfer_s & wbs_we_i;
        rd_s        = xfer_s & ~wbs_we_i;
        reg_s       = reg_off_e'(wbs_adr_i[3:2]);
        ctrl_wr_s   = wr_s & (reg_s == REG_CTRL) & wbs_sel_i[0];
        flush_s     = ctrl_wr_s & wbs_dat_i[CTRL_FLUSH_BIT];
        push_s      = wr_s & (reg_s == REG_CMD) & (wbs_sel_i == 4'hF);
        ovf_set_s   = push_s & full_s;
        ovf_clr_s   = wr_s & (reg_s == REG_STATUS) & wbs_sel_i[0] & wbs_dat_i[ST_OVF_BIT];
        res_clear_s = rd_s & (reg_s == REG_RESULT) & res_held_r;
        capture_s   = res_valid_i & ~res_held_r;
        pop_s       = ~empty_s & cmd_ready_i;
        count_ext_s = 32'(count_s);
    end

    // Read-data mux from pre-edge state.
    always_comb begin
        rdata_s = 32'h0000_0000;
        case (reg_s)
            REG_CTRL:   rdata_s = {30'd0, irq_en_r, enable_r};
            REG_STATUS: rdata_s = pack_status(full_s, empty_s, res_held_r, overflow_r,
                                              count_ext_s[3:0]);
            REG_CMD:    rdata_s = 32'h0000_0000;
            REG_RESULT: rdata_s = res_held_r ? res_r : 32'h0000_0000;
            default:    rdata_s = 32'h0000_0000;
        endcase
    end

    // Bus response, control bits, overflow flag, result slot and interrupt.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_r      <= 1'b0;
            dat_r      <= 32'h0000_0000;
            enable_r   <= 1'b0;
            irq_en_r   <= 1'b0;
            overflow_r <= 1'b0;
            res_held_r <= 1'b0;
            res_r      <= 32'h0000_0000;
            irq_r      <= 1'b0;
        end else begin
            ack_r <= xfer_s;
            dat_r <= rd_s ? rdata_s : 32'h0000_0000;
            if (ctrl_wr_s) begin
                enable_r <= wbs_dat_i[CTRL_EN_BIT];
                irq_en_r <= wbs_dat_i[CTRL_IRQ_EN_BIT];
            end
            if (ovf_set_s) begin
                overflow_r <= 1'b1;
            end else if (ovf_clr_s) begin
                overflow_r <= 1'b0;
            end
            if (capture_s) begin
                res_r      <= res_data_i;
                res_held_r <= 1'b1;
            end else if (res_clear_s) begin
                res_held_r <= 1'b0;
            end
            irq_r <= irq_en_r & (res_held_r | overflow_r);
        end
    end

    tjrpu_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_cmd_fifo (
        .clk       (wb_clk_i),
        .rst_n     (wb_rst_ni),
        .push      (push_s),
        .push_data (wbs_dat_i),
        .pop       (pop_s),
        .flush     (flush_s),
        .full      (full_s),
        .empty     (empty_s),
        .count     (count_s),
        .head      (head_s)
    );

    assign unused_s    = ^{wbs_adr_i[1:0], count_ext_s[31:4]};
    assign wbs_ack_o   = ack_r;
    assign wbs_dat_o   = dat_r;
    assign cmd_valid_o = ~empty_s;
    assign cmd_data_o  = head_s;
    assign res_ready_o = ~res_held_r;
    assign core_en_o   = enable_r;
    assign irq_o       = irq_r;

endmodule

// File: tb/tb_tjrpu_wb_regs.sv
// Bench for tjrpu_wb_regs: per-cycle queue-based reference model feeding a
// read-data scoreboard, directed scenarios followed by randomized traffic.
module tb_tjrpu_wb_regs;
    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam int          DEPTH = 4;

    logic        clk, rst_n;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack;
    logic [31:0] rdat;
    logic        cmd_valid, cmd_ready, res_valid, res_ready, core_en, irq;
    logic [31:0] cmd_data, res_data;
    logic        rand_core;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit          is_read;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_q[$];
    bit          m_en, m_irq_en, m_ovf, m_held, m_irq, m_ack;
    logic [31:0] m_res;

    tjrpu_wb_regs dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .wbs_stb_i   (stb),
        .wbs_cyc_i   (cyc),
        .wbs_we_i    (we),
        .wbs_sel_i   (sel),
        .wbs_adr_i   (adr),
        .wbs_dat_i   (wdat),
        .wbs_ack_o   (ack),
        .wbs_dat_o   (rdat),
        .cmd_valid_o (cmd_valid),
        .cmd_data_o  (cmd_data),
        .cmd_ready_i (cmd_ready),
        .res_valid_i (res_valid),
        .res_data_i  (res_data),
        .res_ready_o (res_ready),
        .core_en_o   (core_en),
        .irq_o       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: compare current outputs, then predict the next edge.
    always @(negedge clk) begin
        bit          hit, do_x, full, pop, cap;
        logic [1:0]  r;
        logic [31:0] rd;
        exp_t        e;
        if (!rst_n) begin
            m_en = 0; m_irq_en = 0; m_ovf = 0; m_held = 0; m_irq = 0; m_ack = 0;
            m_res = 32'h0;
            m_q.delete();
            exp_q.delete();
        end
        check("ack", {31'd0, ack}, {31'd0, m_ack});
        if (!m_ack) check("dat_idle", rdat, 32'h0);
        check("core_en", {31'd0, core_en}, {31'd0, m_en});
        check("irq", {31'd0, irq}, {31'd0, m_irq});
        check("res_ready", {31'd0, res_ready}, {31'd0, !m_held});
        check("cmd_valid", {31'd0, cmd_valid}, {31'd0, m_q.size() != 0});
        if (m_q.size() != 0) check("cmd_data", cmd_data, m_q[0]);
        if (rst_n) begin
            hit  = stb && cyc && (adr[31:4] == BASE[31:4]);
            do_x = hit && !m_ack;
            r    = adr[3:2];
            full = (m_q.size() == DEPTH);
            pop  = (m_q.size() != 0) && cmd_ready;
            cap  = res_valid && !m_held;
            case (r)
                2'd0:    rd = m_en + 2 * m_irq_en;
                2'd1:    rd = (full ? 1 : 0) + (m_q.size() == 0 ? 2 : 0) + (m_held ? 4 : 0)
                              + (m_ovf ? 8 : 0) + 16 * m_q.size();
                2'd3:    rd = m_held ? m_res : 32'h0;
                default: rd = 32'h0;
            endcase
            m_irq = m_irq_en && (m_held || m_ovf);
            if (do_x) begin
                e.is_read = !we;
                e.data    = rd;
                exp_q.push_back(e);
            end
            if (pop) m_q.delete(0);
            if (do_x && we) begin
                case (r)
                    2'd0: if (sel[0]) begin
                        m_en = wdat[0]; m_irq_en = wdat[1];
                        if (wdat[2]) m_q.delete();
                    end
                    2'd1: if (sel[0] && wdat[3]) m_ovf = 0;
                    2'd2: if (sel == 4'hF) begin
                        if (full) m_ovf = 1;
                        else m_q.push_back(wdat);
                    end
                    default: ;
                endcase
            end
            if (cap) begin
                m_res = res_data; m_held = 1;
            end else if (do_x && !we && r == 2'd3) begin
                m_held = 0;
            end
            m_ack = do_x;
        end
    end

    // Scoreboard monitor: every ack consumes one expected response.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && ack) begin
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_ack: got ack with no pending transaction at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                if (e.is_read) check("rdata", rdat, e.data);
            end
        end
    end

    task automatic wb(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bit got = 0;
        @(posedge clk); #1;
        stb = 1; cyc = 1; we = w; adr = a; wdat = d; sel = s;
        if (a[31:4] == BASE[31:4]) begin
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (ack) begin got = 1; break; end
            end
            tests++;
            if (!got) begin
                fails++;
                $display("FAIL ack_timeout: no ack within 8 cycles for address %h", a);
            end
        end else begin
            repeat (8) @(negedge clk);
        end
        @(posedge clk); #1;
        stb = 0; cyc = 0; we = 0;
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] d);
        wb(1'b1, BASE + {28'd0, off}, d, 4'hF);
    endtask

    task automatic rd(input logic [3:0] off);
        wb(1'b0, BASE + {28'd0, off}, 32'h0, 4'hF);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Core-side random stimulus when enabled.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_core) begin
                cmd_ready = 1'($urandom_range(0, 1));
                res_valid = ($urandom_range(0, 3) == 0);
                res_data  = $urandom;
            end
        end
    end

    initial begin
        rst_n = 0; stb = 0; cyc = 0; we = 0; sel = 4'h0; adr = 32'h0; wdat = 32'h0;
        cmd_ready = 0; res_valid = 0; res_data = 32'h0; rand_core = 0;
        cycles(3);
        rst_n = 1;
        cycles(2);

        rd(4'h4);
        wr(4'h0, 32'h3); rd(4'h0);
        wr(4'h0, 32'h7); rd(4'h0);

        for (int i = 0; i < 5; i++) wr(4'h8, 32'h11 + i);
        rd(4'h4);
        cmd_ready = 1; cycles(8); cmd_ready = 0;
        wr(4'h4, 32'h8);

        res_valid = 1; res_data = 32'hDEAD_BEEF;
        cycles(1);
        res_valid = 0;
        cycles(3);
        rd(4'hC); rd(4'hC);
        cycles(3);

        // Push while the core pops on the same edge at count 2.
        wr(4'h8, 32'hA1); wr(4'h8, 32'hA2);
        @(posedge clk); #1;
        stb = 1; cyc = 1; we = 1; adr = BASE + 32'h8; wdat = 32'hA3; sel = 4'hF; cmd_ready = 1;
        @(posedge clk); #1;
        cmd_ready = 0;
        @(posedge clk); #1;
        stb = 0; cyc = 0; we = 0;
        rd(4'h4);

        // Push at full while the core pops: the word is dropped.
        wr(4'h8, 32'hB1); wr(4'h8, 32'hB2);
        @(posedge clk); #1;
        stb = 1; cyc = 1; we = 1; adr = BASE + 32'h8; wdat = 32'hB3; sel = 4'hF; cmd_ready = 1;
        @(posedge clk); #1;
        cmd_ready = 0;
        @(posedge clk); #1;
        stb = 0; cyc = 0; we = 0;
        rd(4'h4);
        wr(4'h0, 32'h7);
        wr(4'h4, 32'h8); rd(4'h4);
        wr(4'h8, 32'hC1); wb(1'b1, BASE + 32'h8, 32'hC2, 4'h7); rd(4'h4);

        // Strobe held for several cycles: acks every other cycle.
        @(posedge clk); #1;
        stb = 1; cyc = 1; we = 0; adr = BASE + 32'h4; sel = 4'hF;
        cycles(6);
        stb = 0; cyc = 0;
        cycles(2);

        wb(1'b0, BASE + 32'h10, 32'h0, 4'hF);

        // Reset in the middle of an access.
        wr(4'h8, 32'hD1); wr(4'h8, 32'hD2);
        @(posedge clk); #1;
        stb = 1; cyc = 1; we = 0; adr = BASE + 32'h4;
        #2 rst_n = 0;
        #1 stb = 0; cyc = 0;
        cycles(3);
        rst_n = 1;
        cycles(4);

        rand_core = 1;
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            logic [3:0]  s;
            a = BASE + {28'd0, 2'(($urandom_range(0, 3))), 2'b00};
            if ($urandom_range(0, 9) == 0) a = a + 32'h10;
            s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            wb(1'($urandom_range(0, 1)), a, $urandom, s);
        end
        rand_core = 0;
        cmd_ready = 0; res_valid = 0;
        cycles(5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
